// File: rtl/norm_approx_mult.sv
// Approximate unsigned multiplier: normalise both operands, multiply the
// top M bits of each, then shift the product back down.
module norm_approx_mult #(
  parameter int N = 16,
  parameter int M = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);

  localparam int CW = $clog2(N);
  localparam int SW = CW + 1;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    NORM1  = 6'b000010,
    NORM2  = 6'b000100,
    MULT   = 6'b001000,
    DENORM = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  state_t state, state_n;

  logic [N-1:0]   a_q, b_q;
  logic [CW-1:0]  cnt1, cnt2;
  logic [SW-1:0]  sh;
  logic [2*N-1:0] r_q;
  logic [M-1:0]   a_top, b_top;
  logic [2*M-1:0] prod;
  logic           zero_op;

  assign a_top   = a_q[N-1 -: M];
  assign b_top   = b_q[N-1 -: M];
  assign prod    = (2*M)'(a_top) * (2*M)'(b_top);
  assign zero_op = (a_in == '0) || (b_in == '0);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = zero_op ? DONE : NORM1;
      end
      NORM1: begin
        if (a_q[N-1]) state_n = NORM2;
      end
      NORM2: begin
        if (b_q[N-1]) state_n = MULT;
      end
      MULT: state_n = DENORM;
      DENORM: begin
        if (sh == '0) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt1   <= '0;
      cnt2   <= '0;
      sh     <= '0;
      r_q    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (zero_op) begin
              result <= '0;
            end else begin
              a_q  <= a_in;
              b_q  <= b_in;
              cnt1 <= '0;
              cnt2 <= '0;
            end
          end
        end
        NORM1: begin
          if (!a_q[N-1]) begin
            a_q  <= a_q << 1;
            cnt1 <= cnt1 + CW'(1);
          end
        end
        NORM2: begin
          if (!b_q[N-1]) begin
            b_q  <= b_q << 1;
            cnt2 <= cnt2 + CW'(1);
          end
        end
        MULT: begin
          // realign the mantissa product to the normalised 2N-bit scale
          r_q <= (2*N)'(prod) << (2*(N-M));
          sh  <= SW'(cnt1) + SW'(cnt2);
        end
        DENORM: begin
          if (sh == '0) begin
            result <= r_q;
          end else begin
            r_q <= r_q >> 1;
            sh  <= sh - SW'(1);
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_approx_mult.sv
// Scoreboard bench for norm_approx_mult: expected result and latency
// are queued at issue and matched on each done pulse.
module tb_norm_approx_mult;

  localparam int N = 16;
  localparam int M = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a_in, b_in;
  logic           busy, done;
  logic [2*N-1:0] result;

  norm_approx_mult #(.N(N), .M(M)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          issue;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  logic [2*N-1:0] prev_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)",
               tag, obs, expv, $time);
    end
  endtask

  function automatic int msb_of(input logic [N-1:0] v);
    int p = -1;
    for (int i = 0; i < N; i++)
      if (v[i]) p = i;
    return p;
  endfunction

  // keep only the M most significant bits counted from the leading one
  function automatic logic [63:0] trunc_val(input logic [N-1:0] v);
    int          p;
    logic [63:0] w;
    p = msb_of(v);
    w = 64'(v);
    if (p >= M) w = (w >> (p - M + 1)) << (p - M + 1);
    return w;
  endfunction

  function automatic exp_t model(input logic [N-1:0] a,
                                 input logic [N-1:0] b);
    exp_t e;
    if (a == '0 || b == '0) begin
      e.res = 64'd0;
      e.lat = 1;
    end else begin
      e.res = trunc_val(a) * trunc_val(b);
      e.lat = 5 + 2 * ((N - 1 - msb_of(a)) + (N - 1 - msb_of(b)));
    end
    e.issue = cyc + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        check("sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("result", 64'(result), e.res);
          check("latency", 64'(cyc - e.issue + 1), 64'(e.lat));
          check("busy_in_done", 64'(busy), 64'd1);
        end
      end else begin
        check("result_hold", 64'(result), 64'(prev_res));
      end
    end
    prev_res = result;
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      check("timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b);
    issue(a, b);
    wait_idle();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst = 1'b1;

    run(16'h8000, 16'h8000);
    run(16'h0001, 16'h0001);
    run(16'h00FF, 16'h0003);
    run(16'h0FFF, 16'h0FFF);
    run(16'hFFFF, 16'hFFFF);
    run(16'h0005, 16'h0007);

    issue(16'h0000, 16'h1234);
    #1;
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_done", 64'(done), 64'd1);
    @(negedge clk);
    #1;
    check("zero_idle_busy", 64'(busy), 64'd0);
    check("zero_idle_done", 64'(done), 64'd0);
    wait_idle();

    for (int k = 0; k < 10; k++) begin
      logic [N-1:0] ma, mb;
      ma = N'((32'd1 << $urandom_range(1, N)) - 1);
      mb = N'((32'd1 << $urandom_range(1, N)) - 1);
      run(N'($urandom) & ma, N'($urandom) & mb);
    end

    // start held high with operands wandering during the operation
    @(negedge clk);
    a_in  = 16'h0123;
    b_in  = 16'h0456;
    start = 1'b1;
    sb.push_back(model(16'h0123, 16'h0456));
    begin
      int n = 0;
      while (n < 200) begin
        @(negedge clk);
        if (done) break;
        a_in = N'($urandom);
        b_in = N'($urandom);
        n++;
      end
      if (n >= 200) check("hold_timeout", 64'd0, 64'd1);
    end
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    run(16'h0ABC, 16'h00DE);

    // abort in DENORM of a long operation
    issue(16'h0001, 16'h0001);
    repeat (38) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    #1;
    check("abort_idle", 64'(busy), 64'd0);
    run(16'h1234, 16'h5678);
    run(16'h0003, 16'h8001);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
